// File: rtl/change_payout_ctrl.sv
// Coin-change payout controller: greedy 10/5/1 selection from a saturating
// per-denomination inventory, one hopper eject at a time with an ack timeout.
module change_payout_ctrl #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       REQ,
  input  logic [7:0] AMOUNT,
  input  logic       LOAD,
  input  logic [1:0] LOAD_DEN,
  input  logic [7:0] LOAD_QTY,
  input  logic       HOP_ACK,
  output logic       C1,
  output logic       C5,
  output logic       C10,
  output logic       BUSY,
  output logic       DONE,
  output logic       SHORT,
  output logic [7:0] SHORT_AMT,
  output logic [7:0] CNT1,
  output logic [7:0] CNT5,
  output logic [7:0] CNT10,
  output logic [1:0] DBG_STATE
);

  // Handshakes: REQ/LOAD are only accepted in IDLE (REQ wins over LOAD).
  // Hopper is a level handshake: Cx holds until HOP_ACK is seen high (or the
  // timeout fires); the next command waits for HOP_ACK to be seen low again.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PICK     = 2'd1,
    EJECT    = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          done_q, done_d;
  logic          short_q, short_d;
  logic [7:0]    short_amt_q, short_amt_d;
  logic [7:0]    cnt1_q, cnt1_d;
  logic [7:0]    cnt5_q, cnt5_d;
  logic [7:0]    cnt10_q, cnt10_d;

  logic          sel10, sel5, sel1;
  logic [7:0]    dval;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign sel10 = (rem_q >= 8'd10) && (cnt10_q != 8'd0);
  assign sel5  = !sel10 && (rem_q >= 8'd5) && (cnt5_q != 8'd0);
  assign sel1  = !sel10 && !sel5 && (rem_q >= 8'd1) && (cnt1_q != 8'd0);

  // cmd_q is one-hot {c10, c5, c1}
  assign dval = cmd_q[2] ? 8'd10 : (cmd_q[1] ? 8'd5 : 8'd1);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    cmd_d       = cmd_q;
    done_d      = 1'b0;
    short_d     = short_q;
    short_amt_d = short_amt_q;
    cnt1_d      = cnt1_q;
    cnt5_d      = cnt5_q;
    cnt10_d     = cnt10_q;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          rem_d       = AMOUNT;
          short_d     = 1'b0;
          short_amt_d = 8'd0;
          state_d     = PICK;
        end else if (LOAD) begin
          case (LOAD_DEN)
            2'b00:   cnt1_d  = sat_add(cnt1_q, LOAD_QTY);
            2'b01:   cnt5_d  = sat_add(cnt5_q, LOAD_QTY);
            2'b10:   cnt10_d = sat_add(cnt10_q, LOAD_QTY);
            default: ;
          endcase
        end
      end
      PICK: begin
        if (sel10 || sel5 || sel1) begin
          if (!HOP_ACK) begin
            cmd_d   = {sel10, sel5, sel1};
            tmo_d   = '0;
            state_d = EJECT;
          end
        end else begin
          done_d      = 1'b1;
          short_d     = (rem_q != 8'd0);
          short_amt_d = rem_q;
          state_d     = IDLE;
        end
      end
      EJECT: begin
        if (HOP_ACK) begin
          cmd_d = 3'b000;
          rem_d = rem_q - dval;
          if (cmd_q[2]) cnt10_d = cnt10_q - 8'd1;
          if (cmd_q[1]) cnt5_d  = cnt5_q - 8'd1;
          if (cmd_q[0]) cnt1_d  = cnt1_q - 8'd1;
          state_d = WAIT_REL;
        end else if (tmo_q == TMO_LAST) begin
          // Silent hopper: treat that tube as empty and retry with smaller coins
          cmd_d = 3'b000;
          if (cmd_q[2]) cnt10_d = 8'd0;
          if (cmd_q[1]) cnt5_d  = 8'd0;
          if (cmd_q[0]) cnt1_d  = 8'd0;
          state_d = PICK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!HOP_ACK) state_d = PICK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      rem_q       <= 8'd0;
      tmo_q       <= '0;
      cmd_q       <= 3'b000;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      short_amt_q <= 8'd0;
      cnt1_q      <= 8'd0;
      cnt5_q      <= 8'd0;
      cnt10_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      done_q      <= done_d;
      short_q     <= short_d;
      short_amt_q <= short_amt_d;
      cnt1_q      <= cnt1_d;
      cnt5_q      <= cnt5_d;
      cnt10_q     <= cnt10_d;
    end
  end

  assign C10       = cmd_q[2];
  assign C5        = cmd_q[1];
  assign C1        = cmd_q[0];
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign SHORT     = short_q;
  assign SHORT_AMT = short_amt_q;
  assign CNT1      = cnt1_q;
  assign CNT5      = cnt5_q;
  assign CNT10     = cnt10_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Bench for change_payout_ctrl: directed payout scenarios, a hopper model,
// and an event monitor checking eject pulses and DONE reports against exp_q.
module tb_change_payout_ctrl;

  localparam int W = 48;

  logic       clk = 1'b1;
  logic       nrst, req, load, hop_ack;
  logic [7:0] amount, load_qty;
  logic [1:0] load_den;
  logic       C1, C5, C10, BUSY, DONE, SHORT;
  logic [7:0] SHORT_AMT, CNT1, CNT5, CNT10;
  logic [1:0] DBG_STATE;
  logic [2:0] ack_mask;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  change_payout_ctrl #(.ACK_TIMEOUT(15)) dut (
    .CLOCK(clk), .nRESET(nrst), .REQ(req), .AMOUNT(amount),
    .LOAD(load), .LOAD_DEN(load_den), .LOAD_QTY(load_qty), .HOP_ACK(hop_ack),
    .C1(C1), .C5(C5), .C10(C10), .BUSY(BUSY), .DONE(DONE), .SHORT(SHORT),
    .SHORT_AMT(SHORT_AMT), .CNT1(CNT1), .CNT5(CNT5), .CNT10(CNT10),
    .DBG_STATE(DBG_STATE)
  );

  function automatic logic [W-1:0] ej_ev(input logic [7:0] den, input logic [7:0] width);
    return {den, width, 32'h0};
  endfunction

  function automatic logic [W-1:0] done_ev(input logic s, input logic [7:0] amt,
                                           input logic [7:0] c10, input logic [7:0] c5,
                                           input logic [7:0] c1);
    return {8'hDD, 7'h0, s, amt, c10, c5, c1};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_pop(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: unexpected event %h with nothing expected", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Hopper: acknowledges any enabled command half a cycle after seeing it
  initial begin
    hop_ack = 1'b0;
    forever begin
      @(posedge clk);
      hop_ack = |({C10, C5, C1} & ack_mask);
    end
  end

  // Monitor: eject events report denomination and pulse width, DONE reports status
  initial begin
    logic [2:0] prev, cur;
    logic [7:0] width, tag;
    prev = 3'b000; width = 8'd0; tag = 8'd0;
    forever begin
      @(posedge clk);
      cur = {C10, C5, C1};
      if (cur != 3'b000) begin
        if (prev == 3'b000) begin
          width = 8'd1;
          tag   = cur[2] ? 8'd10 : (cur[1] ? 8'd5 : 8'd1);
        end else begin
          width = width + 8'd1;
        end
      end else if (prev != 3'b000) begin
        compare_pop("eject", ej_ev(tag, width));
      end
      if (DONE) compare_pop("done", done_ev(SHORT, SHORT_AMT, CNT10, CNT5, CNT1));
      prev = cur;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    nrst = 1'b0; req = 1'b0; load = 1'b0;
    @(posedge clk);
    nrst = 1'b1;
  endtask

  task automatic do_load(input logic [1:0] den, input logic [7:0] qty);
    @(posedge clk);
    load = 1'b1; load_den = den; load_qty = qty;
    @(posedge clk);
    load = 1'b0;
  endtask

  task automatic do_req(input logic [7:0] a);
    @(posedge clk);
    req = 1'b1; amount = a;
    @(posedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(name, {47'h0, BUSY}, '0);
    @(posedge clk);
  endtask

  initial begin
    nrst = 1'b0; req = 1'b0; load = 1'b0; amount = 8'd0;
    load_den = 2'b00; load_qty = 8'd0; ack_mask = 3'b111;
    #12;
    check("reset_state", {8'h0, C10, C5, C1, BUSY, DONE, SHORT, SHORT_AMT,
                          CNT10, CNT5, CNT1, DBG_STATE}, '0);
    @(posedge clk);
    nrst = 1'b1;

    // 17 from 10x2, 5x2, 1x5: greedy 10+5+1+1
    do_reset();
    do_load(2'b10, 8'd2); do_load(2'b01, 8'd2); do_load(2'b00, 8'd5);
    exp_q.push_back(ej_ev(8'd10, 8'd1));
    exp_q.push_back(ej_ev(8'd5, 8'd1));
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(done_ev(1'b0, 8'd0, 8'd1, 8'd1, 8'd3));
    do_req(8'd17);
    wait_idle("idle_a");

    // 13 from 5x1, 1x2: only 7 deliverable, 6 short
    do_reset();
    do_load(2'b01, 8'd1); do_load(2'b00, 8'd2);
    exp_q.push_back(ej_ev(8'd5, 8'd1));
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(done_ev(1'b1, 8'd6, 8'd0, 8'd0, 8'd0));
    do_req(8'd13);
    wait_idle("idle_b");

    // Zero amount: one busy cycle, DONE next, SHORT cleared
    exp_q.push_back(done_ev(1'b0, 8'd0, 8'd0, 8'd0, 8'd0));
    do_req(8'd0);
    check("zero_busy", {43'h0, BUSY, DONE, C10, C5, C1}, {43'h0, 5'b10000});
    @(posedge clk);
    check("zero_done", {43'h0, BUSY, DONE, C10, C5, C1}, {43'h0, 5'b01000});
    wait_idle("idle_c");

    // C10 never acknowledged: 15-cycle pulse, then fall back to two fives
    do_reset();
    do_load(2'b10, 8'd1); do_load(2'b01, 8'd2);
    ack_mask = 3'b011;
    exp_q.push_back(ej_ev(8'd10, 8'd15));
    exp_q.push_back(ej_ev(8'd5, 8'd1));
    exp_q.push_back(ej_ev(8'd5, 8'd1));
    exp_q.push_back(done_ev(1'b0, 8'd0, 8'd0, 8'd0, 8'd0));
    do_req(8'd10);
    wait_idle("idle_d");
    ack_mask = 3'b111;

    // Saturating loads, no-op selector, loads ignored while busy or alongside REQ
    do_reset();
    do_load(2'b00, 8'd250);
    check("load_250", {40'h0, CNT1}, {40'h0, 8'd250});
    do_load(2'b00, 8'd10);
    check("load_sat", {40'h0, CNT1}, {40'h0, 8'd255});
    do_load(2'b00, 8'd10);
    check("load_sat2", {40'h0, CNT1}, {40'h0, 8'd255});
    do_load(2'b11, 8'd9);
    check("load_noop", {24'h0, CNT10, CNT5, CNT1}, {24'h0, 8'd0, 8'd0, 8'd255});
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(ej_ev(8'd1, 8'd1));
    exp_q.push_back(done_ev(1'b0, 8'd0, 8'd0, 8'd0, 8'd252));
    do_req(8'd3);
    @(posedge clk);
    load = 1'b1; load_den = 2'b01; load_qty = 8'd5;
    repeat (4) @(posedge clk);
    load = 1'b0;
    wait_idle("idle_e1");
    exp_q.push_back(done_ev(1'b0, 8'd0, 8'd0, 8'd0, 8'd252));
    @(posedge clk);
    req = 1'b1; amount = 8'd0; load = 1'b1; load_den = 2'b10; load_qty = 8'd7;
    @(posedge clk);
    req = 1'b0; load = 1'b0;
    wait_idle("idle_e2");

    // Asynchronous reset while C5 is held
    do_reset();
    do_load(2'b01, 8'd1);
    ack_mask = 3'b000;
    exp_q.push_back(ej_ev(8'd5, 8'd3));
    do_req(8'd5);
    begin
      int n;
      n = 0;
      while (!C5 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    check("c5_seen", {47'h0, C5}, {47'h0, 1'b1});
    repeat (2) @(posedge clk);
    #2 nrst = 1'b0;
    #1 check("reset_async", {18'h0, C10, C5, C1, BUSY, DONE, SHORT, CNT10, CNT5, CNT1}, '0);
    @(posedge clk);
    nrst = 1'b1;
    ack_mask = 3'b111;
    exp_q.push_back(done_ev(1'b1, 8'd9, 8'd0, 8'd0, 8'd0));
    do_req(8'd9);
    wait_idle("idle_f");

    repeat (5) @(posedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
